// File: rtl/lane_arb_pkg.sv
// Shared constants and the grant index type for the two-requester lane arbiter.
package lane_arb_pkg;

    localparam int LANE_DW   = 8;
    localparam int DEF_DEPTH = 4;
    localparam int GCNT_W    = 16;

    typedef enum logic {
        GRANT_0 = 1'b0,
        GRANT_1 = 1'b1
    } grant_t;

endpackage

// File: rtl/lane_byte_fifo.sv
// Small per-requester FIFO; the head is read asynchronously so a byte pushed at
// edge N can be popped at edge N+1.
module lane_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [DW-1:0]          din,
    input  logic                   pop,
    output logic [DW-1:0]          head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] lvl
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   lvl_reg;
    logic          do_push;
    logic          do_pop;

    assign full    = (lvl_reg == (AW+1)'(DEPTH));
    assign empty   = (lvl_reg == '0);
    assign lvl     = lvl_reg;
    assign head    = mem[rd_ptr_reg];
    // A full FIFO refuses pushes even when popped in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            lvl_reg    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   lvl_reg <= lvl_reg + 1'b1;
                2'b01:   lvl_reg <= lvl_reg - 1'b1;
                default: lvl_reg <= lvl_reg;
            endcase
        end
    end

endmodule

// File: rtl/lane_arbiter_2x8.sv
// Round-robin arbiter sharing one registered byte lane between two FIFO-backed
// requesters. Define ARB_GRANT_CNT_EN to add per-requester grant counters.
module lane_arbiter_2x8
    import lane_arb_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int DW    = LANE_DW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DW-1:0]          In0,
    input  logic                   valid0,
    output logic                   ready0,
    input  logic [DW-1:0]          In1,
    input  logic                   valid1,
    output logic                   ready1,
    input  logic                   out_pause,
    output logic [DW-1:0]          data_out,
    output logic                   outValid,
    output logic                   out_src,
    output logic [$clog2(DEPTH):0] lvl0,
    output logic [$clog2(DEPTH):0] lvl1
`ifdef ARB_GRANT_CNT_EN
    ,
    input  logic                   cnt_clr,
    output logic [GCNT_W-1:0]      gcnt0,
    output logic [GCNT_W-1:0]      gcnt1
`endif
);

    logic [DW-1:0]          din_v   [2];
    logic [DW-1:0]          head_v  [2];
    logic [$clog2(DEPTH):0] lvl_v   [2];
    logic [1:0]             valid_v;
    logic [1:0]             ready_v;
    logic [1:0]             full_v;
    logic [1:0]             empty_v;
    logic [1:0]             pop_v;
    logic                   grant_valid;
    grant_t                 grant_id;
    grant_t                 last_grant_reg;

    assign din_v[0] = In0;
    assign din_v[1] = In1;
    assign valid_v  = {valid1, valid0};
    assign ready0   = ready_v[0];
    assign ready1   = ready_v[1];
    assign lvl0     = lvl_v[0];
    assign lvl1     = lvl_v[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign ready_v[gi] = !full_v[gi] && !reset;
            assign pop_v[gi]   = grant_valid && (grant_id == grant_t'(gi));

            lane_byte_fifo #(
                .DEPTH (DEPTH),
                .DW    (DW)
            ) u_fifo (
                .clk   (clk),
                .reset (reset),
                .push  (valid_v[gi] && ready_v[gi]),
                .din   (din_v[gi]),
                .pop   (pop_v[gi]),
                .head  (head_v[gi]),
                .full  (full_v[gi]),
                .empty (empty_v[gi]),
                .lvl   (lvl_v[gi])
            );
        end
    endgenerate

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = GRANT_0;
        if (!out_pause && (empty_v != 2'b11)) begin
            grant_valid = 1'b1;
            if (empty_v == 2'b00) begin
                grant_id = (last_grant_reg == GRANT_0) ? GRANT_1 : GRANT_0;
            end else if (!empty_v[1]) begin
                grant_id = GRANT_1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out       <= '0;
            outValid       <= 1'b0;
            out_src        <= 1'b0;
            last_grant_reg <= GRANT_1;
        end else begin
            outValid <= grant_valid;
            if (grant_valid) begin
                data_out       <= head_v[grant_id];
                out_src        <= grant_id;
                last_grant_reg <= grant_id;
            end
        end
    end

`ifdef ARB_GRANT_CNT_EN
    logic [GCNT_W-1:0] gcnt_reg [2];

    assign gcnt0 = gcnt_reg[0];
    assign gcnt1 = gcnt_reg[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (reset || cnt_clr) begin
                    gcnt_reg[gi] <= '0;
                end else if (pop_v[gi] && (gcnt_reg[gi] != {GCNT_W{1'b1}})) begin
                    gcnt_reg[gi] <= gcnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate
`endif

endmodule

// File: tb/tb_lane_arbiter_2x8.sv
// Bench for lane_arbiter_2x8: directed scenarios then random traffic, all checked
// against a queue-based model of the arbitration rules.
module tb_lane_arbiter_2x8;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] In0 = '0, In1 = '0;
    logic       valid0 = 1'b0, valid1 = 1'b0;
    logic       ready0, ready1;
    logic       out_pause = 1'b0;
    logic [7:0] data_out;
    logic       outValid, out_src;
    logic [2:0] lvl0, lvl1;
    logic       cnt_clr = 1'b0;
`ifdef ARB_GRANT_CNT_EN
    logic [15:0] gcnt0, gcnt1;
`endif

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [7:0] q0[$], q1[$];
    bit         lg;
    logic [7:0] exp_data;
    bit         exp_valid, exp_src;
    int         gc0, gc1;

    lane_arbiter_2x8 #(.DEPTH(DEPTH), .DW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .In0       (In0),
        .valid0    (valid0),
        .ready0    (ready0),
        .In1       (In1),
        .valid1    (valid1),
        .ready1    (ready1),
        .out_pause (out_pause),
        .data_out  (data_out),
        .outValid  (outValid),
        .out_src   (out_src),
        .lvl0      (lvl0),
        .lvl1      (lvl1)
`ifdef ARB_GRANT_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .gcnt0     (gcnt0),
        .gcnt1     (gcnt1)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("data_out", 32'(data_out), 32'(exp_data));
        chk("outValid", 32'(outValid), 32'(exp_valid));
        chk("out_src",  32'(out_src),  32'(exp_src));
        chk("lvl0",     32'(lvl0),     32'(q0.size()));
        chk("lvl1",     32'(lvl1),     32'(q1.size()));
`ifdef ARB_GRANT_CNT_EN
        chk("gcnt0",    32'(gcnt0),    32'(gc0));
        chk("gcnt1",    32'(gcnt1),    32'(gc1));
`endif
    endtask

    // One clock cycle: drive inputs, check ready, advance the model, check outputs.
    task automatic step(input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1,
                        input bit p, input bit clr);
        bit acc0, acc1, g;
        valid0 = v0; In0 = d0; valid1 = v1; In1 = d1; out_pause = p; cnt_clr = clr;
        #1;
        chk("ready0", 32'(ready0), 32'(q0.size() < DEPTH));
        chk("ready1", 32'(ready1), 32'(q1.size() < DEPTH));
        acc0 = v0 && (q0.size() < DEPTH);
        acc1 = v1 && (q1.size() < DEPTH);
        if (!p && (q0.size() != 0 || q1.size() != 0)) begin
            if (q0.size() != 0 && q1.size() != 0) g = !lg;
            else g = (q1.size() != 0);
            exp_data  = g ? q1.pop_front() : q0.pop_front();
            exp_valid = 1'b1;
            exp_src   = g;
            lg        = g;
            if (g) gc1 = (gc1 < 65535) ? gc1 + 1 : gc1;
            else   gc0 = (gc0 < 65535) ? gc0 + 1 : gc0;
        end else begin
            exp_valid = 1'b0;
        end
        if (clr) begin
            gc0 = 0;
            gc1 = 0;
        end
        if (acc0) q0.push_back(d0);
        if (acc1) q1.push_back(d1);
        @(posedge clk);
        #1;
        $display("step v0=%0b d0=%h v1=%0b d1=%h pause=%0b -> data_out=%h outValid=%0b src=%0b lvl0=%0d lvl1=%0d",
                 v0, d0, v1, d1, p, data_out, outValid, out_src, lvl0, lvl1);
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1; valid0 = 1'b0; valid1 = 1'b0; out_pause = 1'b0; cnt_clr = 1'b0;
        #1;
        chk("ready0_in_reset", 32'(ready0), 32'd0);
        chk("ready1_in_reset", 32'(ready1), 32'd0);
        @(posedge clk);
        q0.delete(); q1.delete();
        lg = 1'b1; exp_data = '0; exp_valid = 1'b0; exp_src = 1'b0; gc0 = 0; gc1 = 0;
        #1;
        reset = 1'b0;
        $display("reset -> data_out=%h outValid=%0b src=%0b lvl0=%0d lvl1=%0d",
                 data_out, outValid, out_src, lvl0, lvl1);
        check_outputs();
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // idle after reset
        step(0, 8'h00, 0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 8'h00, 0, 0);

        // single byte on requester 0
        step(1, 8'hA5, 0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 8'h00, 0, 0);

        // both streaming from the same cycle: strict alternation
        for (int i = 0; i < 6; i++) step(1, 8'h10 + 8'(i), 1, 8'h20 + 8'(i), 0, 0);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 0, 8'h00, 0, 0);

        // pause while requester 1 pushes five bytes, then drain
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 8'hB0 + 8'(i), 1, 0);
        for (int i = 0; i < 6; i++) step(0, 8'h00, 0, 8'h00, 0, 0);

        // reset with three bytes queued on requester 0
        for (int i = 0; i < 3; i++) step(1, 8'hC0 + 8'(i), 0, 8'h00, 1, 0);
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 8'h00, 0, 0);

        // grant counts: three to requester 0, two to requester 1, then clear
        for (int i = 0; i < 2; i++) step(1, 8'hD0 + 8'(i), 1, 8'hE0 + 8'(i), 0, 0);
        step(1, 8'hD2, 0, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 8'h00, 0, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 31) == 0));
        end
        for (int i = 0; i < 10; i++) step(0, 8'h00, 0, 8'h00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lane_arbiter_2x8.md
Name: lane_arbiter_2x8

Overview:
- Round-robin arbiter that shares one registered 8-bit output lane between two byte requesters.
- Each requester has its own small FIFO with a valid/ready handshake, so no byte is dropped when both send in the same cycle.
- Sits upstream of the lane striping/unstriping logic in the PCIe physical-layer datapath.
- Replaces plain alternate-cycle muxing with fair, loss-free sharing and downstream backpressure.

Parameters:
- DEPTH, 4, entries per requester FIFO; power of two, at least 2.
- DW, 8, data width of each lane in bits.

Ports:
- clk  in  1  single clock; all logic updates on its rising edge.
- reset  in  1  synchronous reset, active-high.
- In0  in  DW  requester 0 data.
- valid0  in  1  requester 0 has a byte on In0.
- ready0  out  1  requester 0 FIFO can accept a byte.
- In1  in  DW  requester 1 data.
- valid1  in  1  requester 1 has a byte on In1.
- ready1  out  1  requester 1 FIFO can accept a byte.
- out_pause  in  1  downstream stall; no byte is issued while it is high.
- data_out  out  DW  registered output byte.
- outValid  out  1  data_out holds a newly issued byte this cycle.
- out_src  out  1  index of the requester that owns the current data_out.
- lvl0  out  $clog2(DEPTH)+1  occupancy of FIFO 0.
- lvl1  out  $clog2(DEPTH)+1  occupancy of FIFO 1.

Behaviour:
- Reset (sampled at the clk edge while reset=1):
  - Both FIFOs emptied; lvl0=lvl1=0.
  - data_out=0, outValid=0, out_src=0.
  - last_grant=1, so requester 0 wins the first tie.
  - ready0=ready1=0 while reset is high.
  - Reset mid-operation discards all queued bytes. No output is produced in the cycle after reset.
- Accept rule: a byte is accepted when validN=1 and readyN=1 at a clk edge.
  - readyN = !fullN && !reset, derived from registered state only.
  - A full FIFO refuses a push even if it is popped in the same cycle. This keeps ready free of combinational paths.
- Grant state: a one-bit last_grant register.
  - Candidates are the non-empty FIFOs.
  - If out_pause=1 or there are no candidates: no pop; outValid<=0; data_out and out_src hold.
  - One candidate: grant it.
  - Two candidates: grant the requester != last_grant.
  - On a grant: pop that FIFO head; data_out<=head; out_src<=id; outValid<=1; last_grant<=id.
- Latency: a byte accepted into an empty FIFO at edge N is eligible for a grant at edge N+1. It appears on data_out with outValid=1 right after edge N+1, if there is no pause and it wins arbitration.
- Throughput: one byte per cycle in total. With both requesters streaming, output strictly alternates 0,1,0,1.
- Simultaneous push and pop on the same FIFO: allowed when the FIFO is not full; lvl is unchanged.
- Pointers: wrap modulo DEPTH. lvl counts 0..DEPTH; full when lvl==DEPTH, empty when lvl==0.
- out_pause raised mid-stream: takes effect at the next edge. last_grant is frozen so fairness resumes where it stopped.
- Bytes from each requester leave in acceptance order. There is no ordering between the two requesters beyond the grant order.

Optional Feature:
- Macro: ARB_GRANT_CNT_EN.
- When defined:
  - Adds outputs gcnt0 and gcnt1, 16 bits each, counting grants per requester.
  - Counters are cleared by reset and saturate at 16'hFFFF.
  - Adds input cnt_clr: synchronous clear of both counters. If a grant coincides with cnt_clr, the counter takes 0.
- When undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared package lane_arb_pkg:
  - LANE_DW=8.
  - DEF_DEPTH=4.
  - GCNT_W=16.
  - Grant index typedef (0/1).
- Sub-module lane_byte_fifo:
  - Parameterised by DEPTH and DW, with push/pop/full/empty/lvl.
  - Instantiated twice.
- Arbitration and output registers stay in the top level.

Test Plan:
- Reset, then idle: ready0=ready1=1, outValid=0, data_out=0, lvl0=lvl1=0.
- Push 8'hA5 on requester 0 only at edge N -> after edge N+1: data_out=8'hA5, outValid=1, out_src=0, lvl0=0.
- Both stream from the first cycle (In0 = 8'h10,11,12,…; In1 = 8'h20,21,22,…) -> output is 10,20,11,21,12,22 with out_src alternating 0,1,…
- out_pause=1 while requester 1 pushes 5 bytes (DEPTH=4) -> 4 bytes accepted, ready1=0, lvl1=4.
  - Release pause -> 4 bytes drain in order, one per cycle; ready1 returns to 1 one cycle after the first pop.
- Assert reset for one cycle with lvl0=3 -> lvl0=0, outValid=0, and the queued bytes never appear.
- With ARB_GRANT_CNT_EN: 3 grants to requester 0 and 2 to requester 1 -> gcnt0=3, gcnt1=2; pulse cnt_clr -> both 0.
